// File: rtl/bru_pkg.sv
// Shared types and funct3 encodings for the branch resolve unit.
// Struct fields are sized for the widest supported XLEN; narrower builds use the low bits.
package bru_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [2:0]          funct3;
        logic                is_jal;
        logic                is_jalr;
        logic [XLEN_MAX-1:0] rs1;
        logic [XLEN_MAX-1:0] rs2;
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] imm;
        logic                pred_taken;
        logic [XLEN_MAX-1:0] pred_target;
    } bru_req_t;

    typedef struct packed {
        logic                taken;
        logic [XLEN_MAX-1:0] target;
        logic [XLEN_MAX-1:0] link;
        logic                mispredict;
        logic                misalign;
        logic                illegal;
    } bru_res_t;

endpackage

// File: rtl/branch_cmp.sv
// Combinational conditional-branch evaluator (RV funct3 encoding).
module branch_cmp
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolution with registered result and one-cycle redirect pulse.
// Optional saturating retire counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic             in_is_jal,
    input  logic             in_is_jalr,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target,
    output logic [XLEN-1:0]  out_link,
    output logic             out_mispredict,
    output logic             out_misalign,
    output logic             out_illegal,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispred
);

    bru_req_t        req;
    bru_res_t        s1_res;
    bru_res_t        up_res;
    bru_res_t        o_res;
    logic            cmp_taken;
    logic            cmp_illegal;
    logic            jump;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] br_target;
    logic            accept;
    logic            retire;
    logic            out_adv;
    logic            first_adv;
    logic            up_valid;
    logic            redir_hit;
    logic            unused_bits;

    assign req = '{funct3:      in_funct3,
                   is_jal:      in_is_jal,
                   is_jalr:     in_is_jalr,
                   rs1:         XLEN_MAX'(in_rs1),
                   rs2:         XLEN_MAX'(in_rs2),
                   pc:          XLEN_MAX'(in_pc),
                   imm:         XLEN_MAX'(in_imm),
                   pred_taken:  in_pred_taken,
                   pred_target: XLEN_MAX'(in_pred_target)};

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (req.funct3),
        .rs1     (req.rs1[XLEN-1:0]),
        .rs2     (req.rs2[XLEN-1:0]),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    assign jump      = req.is_jal | req.is_jalr;
    assign jalr_sum  = req.rs1[XLEN-1:0] + req.imm[XLEN-1:0];
    assign br_target = req.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0}
                                   : req.pc[XLEN-1:0] + req.imm[XLEN-1:0];

    always_comb begin
        s1_res         = '0;
        s1_res.taken   = jump | cmp_taken;
        s1_res.illegal = ~jump & cmp_illegal;
        s1_res.target  = XLEN_MAX'(br_target);
        s1_res.link    = XLEN_MAX'(req.pc[XLEN-1:0] + XLEN'(4));
    end

    // Prediction check; the second pipeline stage when PIPE_STAGES=2.
    function automatic bru_res_t resolve(input bru_res_t r, input logic pt,
                                         input logic [XLEN-1:0] ptgt);
        bru_res_t        f;
        logic [XLEN-1:0] tgt;
        f            = r;
        tgt          = r.target[XLEN-1:0];
        f.misalign   = r.taken & (tgt[1:0] != 2'b00);
        f.mispredict = ~r.illegal & ((r.taken != pt) | (r.taken & (tgt != ptgt)));
        return f;
    endfunction

    assign out_adv  = ~out_valid | out_ready;
    assign in_ready = ~flush & first_adv;
    assign accept   = in_valid & in_ready;
    assign retire   = out_valid & out_ready;

    generate
        if (PIPE_STAGES == 1) begin : g_pipe1
            assign first_adv = out_adv;
            assign up_valid  = accept;
            assign up_res    = resolve(s1_res, req.pred_taken, req.pred_target[XLEN-1:0]);
        end else begin : g_pipe2
            logic            a_valid;
            bru_res_t        a_res;
            logic            a_pt;
            logic [XLEN-1:0] a_ptgt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_valid <= 1'b0;
                    a_res   <= '0;
                    a_pt    <= 1'b0;
                    a_ptgt  <= '0;
                end else begin
                    if (flush)
                        a_valid <= 1'b0;
                    else if (first_adv)
                        a_valid <= accept;
                    if (accept) begin
                        a_res  <= s1_res;
                        a_pt   <= req.pred_taken;
                        a_ptgt <= req.pred_target[XLEN-1:0];
                    end
                end
            end

            assign first_adv = ~a_valid | out_adv;
            assign up_valid  = a_valid;
            assign up_res    = resolve(a_res, a_pt, a_ptgt);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            o_res     <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (out_adv)
                out_valid <= up_valid;
            if (out_adv && up_valid && !flush)
                o_res <= up_res;
        end
    end

    assign out_taken      = o_res.taken;
    assign out_target     = o_res.target[XLEN-1:0];
    assign out_link       = o_res.link[XLEN-1:0];
    assign out_mispredict = o_res.mispredict;
    assign out_misalign   = o_res.misalign;
    assign out_illegal    = o_res.illegal;

    assign redir_hit = retire & o_res.mispredict & ~o_res.misalign & ~o_res.illegal & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= redir_hit;
            if (redir_hit)
                redirect_pc <= o_res.taken ? out_target : out_link;
        end
    end

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (retire) begin
            if (br_cnt != '1)
                br_cnt <= br_cnt + CNT_W'(1);
            if (o_res.mispredict && !o_res.illegal && mp_cnt != '1)
                mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end

    assign perf_branches = br_cnt;
    assign perf_mispred  = mp_cnt;
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

    // Upper struct bits are constant when XLEN < XLEN_MAX.
    assign unused_bits = ^{req, o_res};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed cases, random traffic vs a reference model.
module tb_branch_resolve_unit;

    localparam int PS    = 2;
    localparam int CW    = 4;
    localparam int PMAX  = (1 << CW) - 1;
`ifdef BRU_PERF_CNT_EN
    localparam int PSAT  = PMAX;
`else
    localparam int PSAT  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_funct3 = '0;
    logic          in_is_jal = 1'b0;
    logic          in_is_jalr = 1'b0;
    logic [31:0]   in_rs1 = '0, in_rs2 = '0, in_pc = '0, in_imm = '0;
    logic          in_pred_taken = 1'b0;
    logic [31:0]   in_pred_target = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_taken;
    logic [31:0]   out_target, out_link;
    logic          out_mispredict, out_misalign, out_illegal;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] perf_branches, perf_mispred;

    branch_resolve_unit #(.XLEN(32), .PIPE_STAGES(PS), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_is_jal(in_is_jal), .in_is_jalr(in_is_jalr),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_target(out_target), .out_link(out_link),
        .out_mispredict(out_mispredict), .out_misalign(out_misalign), .out_illegal(out_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .perf_branches(perf_branches), .perf_mispred(perf_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        jal, jalr;
        logic [31:0] rs1, rs2, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
    } op_t;

    typedef struct {
        logic        taken;
        logic [31:0] target, link;
        logic        misp, misal, ill;
        int          acc_cyc;
        int          stall;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    bit          prev_stall = 0;
    logic [31:0] m_rpc = '0;
    int          m_br = 0, m_mp = 0;
    exp_t        q[$];
    op_t         cur_op;
    logic        lr_taken, lr_misp, lr_misal, lr_ill;
    logic [31:0] lr_target, lr_link;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference: architectural branch semantics on 32-bit wrapping values.
    function automatic exp_t model(input op_t o);
        exp_t e;
        e = '{default: 0};
        if (o.jal || o.jalr) e.taken = 1'b1;
        else case (o.f3)
            3'd0: e.taken = (o.rs1 == o.rs2);
            3'd1: e.taken = (o.rs1 != o.rs2);
            3'd4: e.taken = ($signed(o.rs1) <  $signed(o.rs2));
            3'd5: e.taken = ($signed(o.rs1) >= $signed(o.rs2));
            3'd6: e.taken = (o.rs1 <  o.rs2);
            3'd7: e.taken = (o.rs1 >= o.rs2);
            default: e.ill = 1'b1;
        endcase
        e.link   = o.pc + 32'd4;
        e.target = o.jalr ? ((o.rs1 + o.imm) & 32'hFFFF_FFFE) : (o.pc + o.imm);
        e.misal  = e.taken && (e.target % 4 != 0);
        e.misp   = !e.ill && ((e.taken != o.pt) || (e.taken && e.target != o.ptgt));
        return e;
    endfunction

    function automatic op_t mk(input logic [2:0] f3, input logic jal, input logic jalr,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic pt, input logic [31:0] ptgt);
        op_t o;
        o.f3 = f3; o.jal = jal; o.jalr = jalr; o.rs1 = rs1; o.rs2 = rs2;
        o.pc = pc; o.imm = imm; o.pt = pt; o.ptgt = ptgt;
        return o;
    endfunction

    function automatic op_t gen_op();
        op_t  o;
        exp_t e;
        int   k;
        o.f3   = 3'($urandom_range(0, 7));
        k      = $urandom_range(0, 9);
        o.jal  = (k == 0 || k == 2);
        o.jalr = (k == 1 || k == 2);
        o.rs1  = $urandom;
        o.rs2  = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
        if ($urandom_range(0, 3) == 0) begin
            o.rs1 = 32'($urandom_range(0, 3)) - 32'd1;
            o.rs2 = 32'($urandom_range(0, 3)) - 32'd1;
        end
        o.pc  = $urandom & 32'hFFFF_FFFC;
        o.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        if ($urandom_range(0, 7) != 0) o.imm[1:0] = 2'b00;
        o.pt   = 1'($urandom_range(0, 1));
        o.ptgt = $urandom;
        e = model(o);
        if ($urandom_range(0, 1) == 1) o.ptgt = e.target;
        return o;
    endfunction

    task automatic drive(input op_t o);
        cur_op = o;
        in_funct3 = o.f3; in_is_jal = o.jal; in_is_jalr = o.jalr;
        in_rs1 = o.rs1; in_rs2 = o.rs2; in_pc = o.pc; in_imm = o.imm;
        in_pred_taken = o.pt; in_pred_target = o.ptgt;
    endtask

    // One clock cycle: sample handshakes at negedge, check redirect/perf after the posedge.
    task automatic tick(output bit acc, output bit ret);
        exp_t        e;
        bit          rv;
        logic [31:0] rpc;
        rv  = 0;
        rpc = '0;
        @(negedge clk);
        cyc++;
        if (!out_ready) stall_cnt++;
        if (flush) chk("in_ready_flush", in_ready, 0);
        else if (out_ready) chk("in_ready_flow", in_ready, 1);
        if (prev_stall) chk("stall_hold_valid", out_valid, 1);
        acc = in_valid && in_ready;
        ret = out_valid && out_ready;
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_valid", out_valid, 0);
            else begin
                e = q[0];
                chk("out_taken", out_taken, e.taken);
                chk("out_target", out_target, e.target);
                chk("out_link", out_link, e.link);
                chk("out_mispredict", out_mispredict, e.misp);
                chk("out_misalign", out_misalign, e.misal);
                chk("out_illegal", out_illegal, e.ill);
                if (ret) begin
                    if (e.stall == stall_cnt) chk("latency", 64'(cyc - e.acc_cyc), PS);
                    lr_taken = out_taken; lr_target = out_target; lr_link = out_link;
                    lr_misp = out_mispredict; lr_misal = out_misalign; lr_ill = out_illegal;
                    void'(q.pop_front());
                    rv = e.misp && !e.misal && !e.ill && !flush;
                    if (rv) rpc = e.taken ? e.target : e.link;
`ifdef BRU_PERF_CNT_EN
                    if (m_br < PMAX) m_br++;
                    if (e.misp && !e.ill && m_mp < PMAX) m_mp++;
`endif
                end
            end
        end
        prev_stall = out_valid && !out_ready && !flush;
        if (acc) begin
            e = model(cur_op);
            e.acc_cyc = cyc;
            e.stall = out_ready ? stall_cnt : -1;
            q.push_back(e);
        end
        if (flush) q.delete();
        @(posedge clk);
        #1;
        chk("redirect_valid", redirect_valid, rv);
        if (rv) m_rpc = rpc;
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("perf_branches", perf_branches, 64'(m_br));
        chk("perf_mispred", perf_mispred, 64'(m_mp));
    endtask

    task automatic run_op(input op_t o);
        bit acc, ret;
        int n;
        drive(o);
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        acc = 0;
        while (!acc && n < 20) begin tick(acc, ret); n++; end
        in_valid = 1'b0;
        chk("accept_timeout", acc, 1);
        n = 0;
        ret = 0;
        while (!ret && n < 20) begin tick(acc, ret); n++; end
        chk("retire_timeout", ret, 1);
    endtask

    task automatic drain();
        bit acc, ret;
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 50) begin tick(acc, ret); n++; end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_taken"}, out_taken, 0);
        chk({tag, "_out_target"}, out_target, 0);
        chk({tag, "_out_link"}, out_link, 0);
        chk({tag, "_out_misp"}, out_mispredict, 0);
        chk({tag, "_out_misal"}, out_misalign, 0);
        chk({tag, "_out_ill"}, out_illegal, 0);
        chk({tag, "_redir_valid"}, redirect_valid, 0);
        chk({tag, "_redir_pc"}, redirect_pc, 0);
        chk({tag, "_perf_br"}, perf_branches, 0);
        chk({tag, "_perf_mp"}, perf_mispred, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, ret;

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        // BEQ equal, predicted not-taken
        run_op(mk(3'd0, 0, 0, 32'h5, 32'h5, 32'h100, 32'h20, 0, 32'h0));
        chk("beq_taken", lr_taken, 1);
        chk("beq_target", lr_target, 32'h120);
        chk("beq_misp", lr_misp, 1);
        chk("beq_redir_valid", redirect_valid, 1);
        chk("beq_redir_pc", redirect_pc, 32'h120);

        // signed vs unsigned less-than
        run_op(mk(3'd4, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1, 32'h240));
        chk("blt_taken", lr_taken, 1);
        chk("blt_misp", lr_misp, 0);
        run_op(mk(3'd6, 0, 0, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 0, 32'h240));
        chk("bltu_taken", lr_taken, 0);

        // reserved funct3
        run_op(mk(3'd2, 0, 0, 32'h1, 32'h1, 32'h200, 32'h40, 1, 32'h0));
        chk("ill_flag", lr_ill, 1);
        chk("ill_taken", lr_taken, 0);
        chk("ill_misp", lr_misp, 0);
        chk("ill_no_redirect", redirect_valid, 0);

        // JALR bit-0 clear, correct and wrong target predictions
        run_op(mk(3'd0, 0, 1, 32'h1001, 32'h0, 32'h300, 32'h4, 1, 32'h1004));
        chk("jalr_target", lr_target, 32'h1004);
        chk("jalr_link", lr_link, 32'h304);
        chk("jalr_misp", lr_misp, 0);
        chk("jalr_no_redirect", redirect_valid, 0);
        run_op(mk(3'd0, 0, 1, 32'h1001, 32'h0, 32'h300, 32'h4, 1, 32'h1008));
        chk("jalr_bad_misp", lr_misp, 1);
        chk("jalr_bad_redir", redirect_valid, 1);
        chk("jalr_bad_redir_pc", redirect_pc, 32'h1004);

        // misaligned taken target: flagged, no redirect
        run_op(mk(3'd0, 1, 0, 32'h0, 32'h0, 32'h400, 32'h2, 1, 32'h400));
        chk("misal_flag", lr_misal, 1);
        chk("misal_target", lr_target, 32'h402);
        chk("misal_no_redirect", redirect_valid, 0);

        // is_jalr wins when both set; PC wrap
        run_op(mk(3'd1, 1, 1, 32'h2000, 32'h0, 32'h500, 32'h10, 1, 32'h2010));
        chk("both_jalr_target", lr_target, 32'h2010);
        run_op(mk(3'd0, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h8, 1, 32'h4));
        chk("wrap_target", lr_target, 32'h4);
        chk("wrap_link", lr_link, 32'h0);

        // back-to-back with out_ready toggling every other cycle
        for (int i = 0; i < 120; i++) begin
            drive(gen_op());
            in_valid = 1'b1;
            out_ready = 1'(i % 2);
            tick(acc, ret);
        end
        // random valid/ready with occasional flush
        for (int i = 0; i < 150; i++) begin
            drive(gen_op());
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            tick(acc, ret);
        end
        flush = 1'b0;
        // sustained full throughput
        for (int i = 0; i < 60; i++) begin
            drive(gen_op());
            in_valid = 1'b1;
            out_ready = 1'b1;
            tick(acc, ret);
        end
        drain();

        // flush with two ops in flight and a third offered
        out_ready = 1'b0;
        drive(mk(3'd0, 0, 0, 32'h7, 32'h7, 32'h600, 32'h30, 0, 32'h0));
        in_valid = 1'b1;
        tick(acc, ret);
        drive(mk(3'd1, 0, 0, 32'h7, 32'h8, 32'h700, 32'h30, 0, 32'h0));
        tick(acc, ret);
        chk("flush_second_accepted", acc, 1);
        drive(mk(3'd0, 1, 0, 32'h0, 32'h0, 32'h800, 32'h40, 0, 32'h0));
        flush = 1'b1;
        out_ready = 1'b1;
        tick(acc, ret);
        chk("flush_cycle_retire", ret, 1);
        chk("flush_redir_suppressed", redirect_valid, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(acc, ret);
            chk("post_flush_valid", out_valid, 0);
        end

        // asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            drive(gen_op());
            in_valid = 1'b1;
            out_ready = 1'b1;
            tick(acc, ret);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        q.delete();
        m_rpc = '0;
        m_br = 0;
        m_mp = 0;
        prev_stall = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 17 mispredicting branches saturate the counters
        drive(mk(3'd0, 0, 0, 32'h9, 32'h9, 32'h900, 32'h100, 0, 32'h0));
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick(acc, ret);
        drain();
        chk("perf_br_saturated", perf_branches, PSAT);
        chk("perf_mp_saturated", perf_mispred, PSAT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
